// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway and pending array.
// Each source runs its own IDLE/PENDING/CLAIMED state machine. The outputs
// feed the priority max-finder: o_val carries the priority gated by pending
// and enable, and o_pld carries the constant source ID (channel i = ID i+1).
// ID 0 is reserved, so no channel ever matches it.
// Optional build macro PLIC_EDGE_TRIG_EN adds per-source rising-edge
// triggering (input i_edge) with a one-deep rearm flag while CLAIMED.
module plic_gateway #(
    parameter  int SRC_N  = 31,
    parameter  int PRIO_W = 3,
    localparam int ID_W   = $clog2(SRC_N + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [SRC_N-1:0]         i_irq,
`ifdef PLIC_EDGE_TRIG_EN
    input  logic [SRC_N-1:0]         i_edge,
`endif
    input  logic [SRC_N*PRIO_W-1:0]  i_prio,
    input  logic [SRC_N-1:0]         i_en,
    input  logic                     i_claim,
    input  logic [ID_W-1:0]          i_claim_id,
    input  logic                     i_complete,
    input  logic [ID_W-1:0]          i_complete_id,
    output logic [SRC_N-1:0]         o_pending,
    output logic [SRC_N*PRIO_W-1:0]  o_val,
    output logic [SRC_N*ID_W-1:0]    o_pld
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } src_state_e;

    src_state_e       state     [SRC_N];
    src_state_e       state_nxt [SRC_N];
    logic [SRC_N-1:0] claim_hit;
    logic [SRC_N-1:0] complete_hit;
    logic [SRC_N-1:0] trigger;
    logic [SRC_N-1:0] pend_vec;

    // Decode claim/complete strobes into one-hot per-source hits.
    // Out-of-range IDs (0 or > SRC_N) simply match no channel.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < SRC_N; i++) begin
            claim_hit[i]    = i_claim    && (i_claim_id    == ID_W'(i + 1));
            complete_hit[i] = i_complete && (i_complete_id == ID_W'(i + 1));
        end
    end

`ifdef PLIC_EDGE_TRIG_EN
    logic [SRC_N-1:0] irq_q;
    logic [SRC_N-1:0] rise;
    logic [SRC_N-1:0] rearm;
    logic [SRC_N-1:0] rearm_nxt;

    // Previous-cycle copy of the raw lines for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q <= '0;
        end else begin
            irq_q <= i_irq;
        end
    end

    assign rise    = i_irq & ~irq_q;
    assign trigger = (i_edge & rise) | (~i_edge & i_irq);

    // One-deep rearm flags remember an edge seen while CLAIMED.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rearm <= '0;
        end else begin
            rearm <= rearm_nxt;
        end
    end
`else
    assign trigger = i_irq;
`endif

    // Per-source state registers; reset returns every source to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SRC_N; i++) begin
                state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < SRC_N; i++) begin
                state[i] <= state_nxt[i];
            end
        end
    end

    // Next-state logic. Claim and complete are each only honoured in the
    // state they apply to, so a same-ID claim+complete resolves naturally.
    always_comb begin
`ifdef PLIC_EDGE_TRIG_EN
        rearm_nxt = '0;
`endif
        for (int i = 0; i < SRC_N; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                IDLE: begin
                    if (trigger[i]) begin
                        state_nxt[i] = PENDING;
                    end
                end
                PENDING: begin
                    if (claim_hit[i]) begin
                        state_nxt[i] = CLAIMED;
                    end
                end
                CLAIMED: begin
`ifdef PLIC_EDGE_TRIG_EN
                    if (complete_hit[i]) begin
                        // An edge seen during the claim (including on this
                        // very cycle) re-enters PENDING directly.
                        if (i_edge[i] && (rearm[i] || rise[i])) begin
                            state_nxt[i] = PENDING;
                        end else begin
                            state_nxt[i] = IDLE;
                        end
                        rearm_nxt[i] = 1'b0;
                    end else begin
                        rearm_nxt[i] = rearm[i] | (i_edge[i] & rise[i]);
                    end
`else
                    if (complete_hit[i]) begin
                        state_nxt[i] = IDLE;
                    end
`endif
                end
                default: begin
                    state_nxt[i] = IDLE;
                end
            endcase
        end
    end

    // Pending bits come straight from the registered state.
    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < SRC_N; i++) begin
            pend_vec[i] = (state[i] == PENDING);
        end
    end

    assign o_pending = pend_vec;

    // Value channels: priority masked by pending and enable, no added latency.
    always_comb begin
        o_val = '0;
        for (int i = 0; i < SRC_N; i++) begin
            if (pend_vec[i] && i_en[i]) begin
                o_val[i*PRIO_W +: PRIO_W] = i_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    // Payload channels are the constant source IDs.
    for (genvar g = 0; g < SRC_N; g++) begin : g_pld
        assign o_pld[g*ID_W +: ID_W] = ID_W'(g + 1);
    end

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed scenarios plus randomized traffic for
// plic_gateway, compared every cycle against a behavioural model.
module tb_plic_gateway;

    localparam int SRC_N  = 31;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic [SRC_N-1:0]        i_irq;
    logic [SRC_N-1:0]        i_edge;
    logic [SRC_N*PRIO_W-1:0] i_prio;
    logic [SRC_N-1:0]        i_en;
    logic                    i_claim;
    logic [ID_W-1:0]         i_claim_id;
    logic                    i_complete;
    logic [ID_W-1:0]         i_complete_id;
    logic [SRC_N-1:0]        o_pending;
    logic [SRC_N*PRIO_W-1:0] o_val;
    logic [SRC_N*ID_W-1:0]   o_pld;

    int n_checks = 0;
    int n_fail   = 0;

    plic_gateway #(.SRC_N(SRC_N), .PRIO_W(PRIO_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_irq        (i_irq),
`ifdef PLIC_EDGE_TRIG_EN
        .i_edge       (i_edge),
`endif
        .i_prio       (i_prio),
        .i_en         (i_en),
        .i_claim      (i_claim),
        .i_claim_id   (i_claim_id),
        .i_complete   (i_complete),
        .i_complete_id(i_complete_id),
        .o_pending    (o_pending),
        .o_val        (o_val),
        .o_pld        (o_pld)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [SRC_N-1:0] m_pend  = '0;
    logic [SRC_N-1:0] m_clm   = '0;
    logic [SRC_N-1:0] m_arm   = '0;
    logic [SRC_N-1:0] m_irq_q = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pend  = '0;
            m_clm   = '0;
            m_arm   = '0;
            m_irq_q = '0;
        end else begin
            for (int i = 0; i < SRC_N; i++) begin
                bit edge_mode, rose, do_claim, do_comp;
`ifdef PLIC_EDGE_TRIG_EN
                edge_mode = i_edge[i];
`else
                edge_mode = 1'b0;
`endif
                rose     = i_irq[i] && !m_irq_q[i];
                do_claim = i_claim    && (int'(i_claim_id)    == i + 1);
                do_comp  = i_complete && (int'(i_complete_id) == i + 1);
                if (m_clm[i]) begin
                    if (do_comp) begin
                        m_clm[i]  = 1'b0;
                        m_pend[i] = edge_mode && (m_arm[i] || rose);
                        m_arm[i]  = 1'b0;
                    end else if (edge_mode && rose) begin
                        m_arm[i] = 1'b1;
                    end
                end else if (m_pend[i]) begin
                    if (do_claim) begin
                        m_pend[i] = 1'b0;
                        m_clm[i]  = 1'b1;
                    end
                end else if (edge_mode ? rose : i_irq[i]) begin
                    m_pend[i] = 1'b1;
                end
            end
            m_irq_q = i_irq;
        end
    end

    function automatic logic [SRC_N*PRIO_W-1:0] exp_val();
        logic [SRC_N*PRIO_W-1:0] v = '0;
        for (int i = 0; i < SRC_N; i++) begin
            int p = int'((i_prio >> (PRIO_W * i)) & 93'd7);
            if (m_pend[i] && i_en[i])
                v = v | ((SRC_N*PRIO_W)'(p) << (PRIO_W * i));
        end
        return v;
    endfunction

    function automatic logic [SRC_N*ID_W-1:0] exp_pld();
        logic [SRC_N*ID_W-1:0] v = '0;
        for (int i = 0; i < SRC_N; i++)
            v = v | ((SRC_N*ID_W)'(i + 1) << (ID_W * i));
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are checked every cycle on the falling edge.
    always @(negedge clk) begin
        check("pending_vec", 160'(o_pending), 160'(m_pend));
        check("val_vec", 160'(o_val), 160'(exp_val()));
        check("pld_vec", 160'(o_pld), 160'(exp_pld()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int ch, input int v);
        i_prio[ch*PRIO_W +: PRIO_W] = PRIO_W'(v);
    endtask

    function automatic logic [PRIO_W-1:0] val_of(input int ch);
        return o_val[ch*PRIO_W +: PRIO_W];
    endfunction

    task automatic do_reset();
        i_irq = '0; i_claim = 0; i_complete = 0;
        i_claim_id = '0; i_complete_id = '0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
    endtask

    task automatic claim(input int id);
        i_claim = 1'b1; i_claim_id = ID_W'(id);
        tick();
        i_claim = 1'b0; i_claim_id = '0;
    endtask

    task automatic complete(input int id);
        i_complete = 1'b1; i_complete_id = ID_W'(id);
        tick();
        i_complete = 1'b0; i_complete_id = '0;
    endtask

    initial begin
        rstn = 1'b0;
        i_irq = '1; i_edge = '0; i_en = '1; i_prio = '1;
        i_claim = 0; i_claim_id = '0; i_complete = 0; i_complete_id = '0;

        // Reset held with all lines high.
        repeat (3) tick();
        check("rst_pending", 160'(o_pending), 160'(0));
        check("rst_val", 160'(o_val), 160'(0));
        rstn = 1'b1;
        tick();
        check("post_rst_pending", 160'(o_pending), 160'(31'h7fff_ffff));

        // Source 5 (channel 4): latched pending, claim, ignored pulses.
        do_reset();
        i_prio = '0; i_en = '1;
        set_prio(4, 3);
        i_irq[4] = 1'b1; tick(); i_irq[4] = 1'b0; tick();
        check("id5_pend", 160'(o_pending[4]), 160'(1));
        check("id5_val", 160'(val_of(4)), 160'(3));
        claim(5);
        check("id5_claim_pend", 160'(o_pending[4]), 160'(0));
        check("id5_claim_val", 160'(val_of(4)), 160'(0));
        i_irq[4] = 1'b1; tick(); i_irq[4] = 1'b0; tick();
        check("id5_claimed_ignore", 160'(o_pending[4]), 160'(0));
        complete(5);
        tick();
        check("id5_idle_after_cpl", 160'(o_pending[4]), 160'(0));

        // Source 7 (channel 6): level held across claim/complete.
        i_irq[6] = 1'b1; tick();
        check("id7_pend", 160'(o_pending[6]), 160'(1));
        claim(7);
        check("id7_claimed", 160'(o_pending[6]), 160'(0));
        tick();
        check("id7_claimed_hold", 160'(o_pending[6]), 160'(0));
        complete(7);
        check("id7_cpl_edge", 160'(o_pending[6]), 160'(0));
        tick();
        check("id7_repend", 160'(o_pending[6]), 160'(1));
        i_irq[6] = 1'b0;

        // Same-cycle claim ID 3 and complete ID 9.
        i_irq[2] = 1'b1; i_irq[8] = 1'b1; tick();
        i_irq[2] = 1'b0; i_irq[8] = 1'b0;
        claim(9);
        i_claim = 1'b1; i_claim_id = ID_W'(3);
        i_complete = 1'b1; i_complete_id = ID_W'(9);
        tick();
        i_claim = 0; i_complete = 0; i_claim_id = '0; i_complete_id = '0;
        check("sim_pend", 160'(o_pending), 160'(31'h40));
        i_irq[2] = 1'b1; i_irq[8] = 1'b1; tick();
        i_irq[2] = 1'b0; i_irq[8] = 1'b0;
        check("sim_states", 160'(o_pending), 160'(31'h140));
        claim(0);
        complete(12);
        claim(12);
        check("ignored_ops", 160'(o_pending), 160'(31'h140));

        // Enable gating on source 5 with priority 6.
        set_prio(4, 6);
        i_irq[4] = 1'b1; tick(); i_irq[4] = 1'b0;
        i_en[4] = 1'b0;
        #1;
        check("en0_val", 160'(val_of(4)), 160'(0));
        check("en0_pend", 160'(o_pending[4]), 160'(1));
        i_en[4] = 1'b1;
        #1;
        check("en1_val", 160'(val_of(4)), 160'(6));
        tick();

`ifdef PLIC_EDGE_TRIG_EN
        // Edge source 2 (channel 1): single pending, rearm across claim.
        do_reset();
        i_edge = '0; i_edge[1] = 1'b1;
        i_irq[1] = 1'b1; tick();
        check("edge_pend", 160'(o_pending[1]), 160'(1));
        claim(2);
        tick();
        check("edge_no_relevel", 160'(o_pending[1]), 160'(0));
        i_irq[1] = 1'b0; tick();
        i_irq[1] = 1'b1; tick();
        complete(2);
        check("edge_rearm", 160'(o_pending[1]), 160'(1));
        i_irq[1] = 1'b0;
`endif

        // Randomized traffic.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int cand[$];
            if ($urandom_range(0, 249) == 0) begin
                rstn = 1'b0; #2; rstn = 1'b1;
            end
            i_irq = SRC_N'($urandom & $urandom & $urandom);
            if (cyc % 8 == 0) begin
                i_prio = (SRC_N*PRIO_W)'({$urandom, $urandom, $urandom});
                i_en   = SRC_N'($urandom | $urandom);
            end
`ifdef PLIC_EDGE_TRIG_EN
            if (cyc % 64 == 0) i_edge = SRC_N'($urandom);
`endif
            cand.delete();
            for (int i = 0; i < SRC_N; i++) if (m_pend[i]) cand.push_back(i + 1);
            i_claim = 1'($urandom_range(0, 1));
            if (cand.size() > 0 && $urandom_range(0, 9) < 7)
                i_claim_id = ID_W'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                i_claim_id = ID_W'($urandom_range(0, 31));
            cand.delete();
            for (int i = 0; i < SRC_N; i++) if (m_clm[i]) cand.push_back(i + 1);
            i_complete = 1'($urandom_range(0, 1));
            if (cand.size() > 0 && $urandom_range(0, 9) < 7)
                i_complete_id = ID_W'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                i_complete_id = ID_W'($urandom_range(0, 31));
            tick();
        end
        i_claim = 0; i_complete = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
